// File: rtl/tff_counter_if.sv
// Control/status bundle for the modulo-N toggle counter.
// The master drives count controls; the slave returns count and flags.
interface tff_counter_if #(
  parameter int WIDTH = 4
) ();
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (output en, output up, output load, output d,
                  input  q,  input  tc, input  wrap);
  modport slave  (input  en, input  up, input  load, input  d,
                  output q,  output tc, output wrap);
endinterface

// File: rtl/tff_counter.sv
// Modulo-MODULUS up/down counter built from one toggle stage per bit:
// each bit flips when its t bit is set, t being q XOR the selected next count.
module tff_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic          clk,
  input  logic          reset,
  tff_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_t;
  logic             w_wrap_next;
  logic             w_at_max;
  logic             w_at_zero;

  // Out-of-range load values saturate to the top of the count range.
  function automatic logic [WIDTH-1:0] f_clamp(input logic [WIDTH-1:0] val);
    f_clamp = (val > MAX) ? MAX : val;
  endfunction

  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] cur,
                                              input logic             dir_up);
    if (dir_up) f_step = (cur == MAX) ? '0  : cur + WIDTH'(1);
    else        f_step = (cur == '0)  ? MAX : cur - WIDTH'(1);
  endfunction

  assign w_at_max  = (r_q == MAX);
  assign w_at_zero = (r_q == '0);

  always_comb begin
    w_next      = r_q;
    w_wrap_next = 1'b0;
    if (bus.load) begin
      w_next = f_clamp(bus.d);
    end else if (bus.en) begin
      w_next      = f_step(r_q, bus.up);
      w_wrap_next = bus.up ? w_at_max : w_at_zero;
    end
  end

  assign w_t = r_q ^ w_next;

  // Toggle stage bank: the only state besides the wrap pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= r_q ^ w_t;
      r_wrap <= w_wrap_next;
    end
  end

  assign bus.q    = r_q;
  assign bus.wrap = r_wrap;
  assign bus.tc   = bus.en & ((bus.up & w_at_max) | (~bus.up & w_at_zero));

endmodule
